// File: rtl/ldpc_enc.sv
// ldpc_enc: systematic QC-LDPC encoder for base matrices with the 802.16e dual-diagonal parity part.
// Info blocks pass straight through while row accumulators build up; C parity blocks follow.
module ldpc_enc #(
    parameter int C     = 12,
    parameter int R     = 24,
    parameter int D     = 96,
    parameter int mtx_w = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [C*R*mtx_w-1:0]     m,
    input  logic [D-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [D-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy
);
    localparam int K  = R - C;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = (C > 1) ? $clog2(C) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(C - 1);
    localparam logic [TW-1:0] T_MID    = TW'(C / 2);
    localparam logic [TW-1:0] T_ZERO   = TW'(0);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_P0   = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    // P^h v with (P^h v)[k] = v[(k+h) mod D]; negative or out-of-range entries are zero blocks.
    function automatic logic [D-1:0] circ_shift(input logic [D-1:0] v, input logic [mtx_w-1:0] h);
        logic [2*D-1:0] dbl;
        dbl = {v, v} >> h;
        if (h[mtx_w-1] || (int'(h) >= D)) begin
            circ_shift = {D{1'b0}};
        end else begin
            circ_shift = dbl[D-1:0];
        end
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   t_q, t_d;
    logic [D-1:0]    lambda_q [C];
    logic [D-1:0]    lambda_d [C];
    logic [D-1:0]    p_q, p_d;
    logic [D-1:0]    p0_q, p0_d;
    logic            busy_q, busy_d;
    logic [D-1:0]    lambda_sum_s;
    logic [mtx_w-1:0] h_info_s [C][K];
    logic [mtx_w-1:0] x_s;
    logic            unused_m_s;

    for (genvar gi = 0; gi < C; gi++) begin : g_row
        for (genvar gj = 0; gj < K; gj++) begin : g_col
            assign h_info_s[gi][gj] = m[(gi*R + gj)*mtx_w +: mtx_w];
        end
    end

    // Only the info columns and the shared shift of parity column K are needed; the rest is implied.
    assign x_s        = m[K*mtx_w +: mtx_w];
    assign unused_m_s = ^m;

    // Output decode: pass-through in LOAD, parity register in PAR, silent in P0
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = p_q;
        out_last  = 1'b0;
        busy      = busy_q;
        case (state_q)
            ST_LOAD: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_data  = in_data;
            end
            ST_P0: begin
                out_valid = 1'b0;
            end
            ST_PAR: begin
                out_valid = 1'b1;
                out_last  = (t_q == T_LAST);
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Next-state logic: accumulate lambda per row during LOAD, then unroll the dual diagonal
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        p_d     = p_q;
        p0_d    = p0_q;
        busy_d  = busy_q;
        lambda_sum_s = {D{1'b0}};
        for (int i = 0; i < C; i++) begin
            lambda_d[i]  = lambda_q[i];
            lambda_sum_s = lambda_sum_s ^ lambda_q[i];
        end
        case (state_q)
            ST_LOAD: begin
                if (in_valid && out_ready) begin
                    for (int i = 0; i < C; i++) begin
                        lambda_d[i] = lambda_q[i] ^ circ_shift(in_data, h_info_s[i][cnt_q]);
                    end
                    busy_d = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_P0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_P0: begin
                // Column K contributes P^x + I + P^x = I to the row sum, so p0 is just the lambda sum.
                p_d     = lambda_sum_s;
                p0_d    = lambda_sum_s;
                t_d     = T_ZERO;
                state_d = ST_PAR;
            end
            ST_PAR: begin
                if (out_ready) begin
                    if (t_q == T_LAST) begin
                        for (int i = 0; i < C; i++) begin
                            lambda_d[i] = {D{1'b0}};
                        end
                        cnt_d   = {CW{1'b0}};
                        t_d     = T_ZERO;
                        busy_d  = 1'b0;
                        state_d = ST_LOAD;
                    end else if (t_q == T_ZERO) begin
                        p_d = lambda_q[0] ^ circ_shift(p0_q, x_s);
                        t_d = t_q + TW'(1);
                    end else begin
                        p_d = p_q ^ lambda_q[t_q] ^ ((t_q == T_MID) ? p0_q : {D{1'b0}});
                        t_d = t_q + TW'(1);
                    end
                end else begin
                    t_d = t_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any codeword in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= {CW{1'b0}};
            t_q     <= T_ZERO;
            p_q     <= {D{1'b0}};
            p0_q    <= {D{1'b0}};
            busy_q  <= 1'b0;
            for (int i = 0; i < C; i++) begin
                lambda_q[i] <= {D{1'b0}};
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            p_q     <= p_d;
            p0_q    <= p0_d;
            busy_q  <= busy_d;
            for (int i = 0; i < C; i++) begin
                lambda_q[i] <= lambda_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ldpc_enc.sv
// tb_ldpc_enc: directed vector bench for ldpc_enc; every codeword is checked for
// systematic pass-through, framing and a zero syndrome against an independent H model.
`timescale 1ns/1ps
module tb_ldpc_enc;
    localparam int C = 12;
    localparam int R = 24;
    localparam int D = 96;
    localparam int W = 8;
    localparam int K = R - C;

    logic               clk = 1'b0;
    logic               rst;
    logic [C*R*W-1:0]   m;
    logic [D-1:0]       in_data;
    logic               in_valid;
    logic               in_ready;
    logic [D-1:0]       out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;

    ldpc_enc #(.C(C), .R(R), .D(D), .mtx_w(W)) dut (
        .clk(clk), .rst(rst), .m(m),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;       // 0 zero, 1 unit s_0, 2 shared random, 3 all ones
        logic [3:0] bp;         // out_ready pattern, bit (cycle mod 4)
        bit         zero_par;   // expect all parity blocks zero
        bit         same_prev;  // expect codeword identical to previous vector
    } vec_t;

    int          nvec = 0;
    int          nerr = 0;
    vec_t        vecs [5];
    logic [D-1:0] info [2*K];
    logic [D-1:0] rand_info [K];
    logic [D-1:0] outb [2*R];
    logic         lastb [2*R];
    logic         busyb [2*R];
    int           in_cyc [2*K];
    int           out_cyc [2*R];
    logic [D-1:0] prev_cw [R];

    task automatic chk(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] hm(input int i, input int j);
        return m[(i*R + j)*W +: W];
    endfunction

    // Reference circulant written bit by bit from the definition
    function automatic logic [D-1:0] pshift(input logic [D-1:0] v, input logic [W-1:0] h);
        logic [D-1:0] r = {D{1'b0}};
        if (h[W-1] || (int'(h) >= D)) return r;
        for (int k = 0; k < D; k++) r[k] = v[(k + int'(h)) % D];
        return r;
    endfunction

    function automatic logic [D-1:0] syn_row(input logic [D-1:0] c [R], input int i);
        logic [D-1:0] acc = {D{1'b0}};
        for (int j = 0; j < R; j++) acc = acc ^ pshift(c[j], hm(i, j));
        return acc;
    endfunction

    task automatic run(input int n_cw, input logic [3:0] bp, input int stop_at);
        int cyc  = 0;
        int nin  = 0;
        int nout = 0;
        while ((nout < n_cw*R) && (nout < stop_at) && (cyc < 1000)) begin
            @(negedge clk);
            out_ready = bp[2'(cyc % 4)];
            if (nin < n_cw*K) begin
                in_valid = 1'b1;
                in_data  = info[nin];
            end else begin
                in_valid = 1'b0;
                in_data  = {D{1'b0}};
            end
            #1;
            if (in_valid && in_ready) begin
                in_cyc[nin] = cyc;
                nin++;
            end
            if (out_valid && out_ready) begin
                outb[nout]    = out_data;
                lastb[nout]   = out_last;
                busyb[nout]   = busy;
                out_cyc[nout] = cyc;
                nout++;
            end
            cyc++;
        end
        nvec++;
        if (cyc >= 1000) begin
            nerr++;
            $display("FAIL timeout: %0d blocks out after %0d cycles, expected %0d", nout, cyc, n_cw*R);
        end
    endtask

    task automatic check_cw(input int cw, input logic [3:0] bp, input bit zero_par,
                            input bit same_prev, input string tag);
        logic [D-1:0] c [R];
        logic [R-1:0] lasts = {R{1'b0}};
        logic [R-1:0] exp_last = {R{1'b0}};
        logic [R-2:0] busys = {(R-1){1'b0}};
        exp_last[R-1] = 1'b1;
        for (int j = 0; j < R; j++) begin
            c[j]     = outb[cw*R + j];
            lasts[j] = lastb[cw*R + j];
        end
        for (int j = 1; j < R; j++) busys[j-1] = busyb[cw*R + j];
        for (int j = 0; j < K; j++) chk($sformatf("%s/sys%0d", tag, j), c[j], info[cw*K + j]);
        chk($sformatf("%s/last", tag), D'(lasts), D'(exp_last));
        chk($sformatf("%s/busy", tag), D'(busys), D'({(R-1){1'b1}}));
        for (int i = 0; i < C; i++) chk($sformatf("%s/syn%0d", tag, i), syn_row(c, i), {D{1'b0}});
        if (zero_par) begin
            for (int t = 0; t < C; t++) chk($sformatf("%s/par%0d", tag, t), c[K + t], {D{1'b0}});
        end
        if (same_prev) begin
            for (int j = 0; j < R; j++) chk($sformatf("%s/same%0d", tag, j), c[j], prev_cw[j]);
        end
        if (bp == 4'b1111) begin
            chk($sformatf("%s/lat", tag), D'(out_cyc[cw*R + K] - in_cyc[cw*K + K - 1]), D'(2));
        end
        for (int j = 0; j < R; j++) prev_cw[j] = c[j];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Base matrix: mixed info shifts with both zero-block encodings, 802.16e parity part (x = 7)
        m = {(C*R*W){1'b1}};
        for (int i = 0; i < C; i++) begin
            for (int j = 0; j < K; j++) begin
                if ((i + j) % 3 == 0)          m[(i*R + j)*W +: W] = 8'hFF;
                else if ((i + 2*j) % 7 == 0)   m[(i*R + j)*W +: W] = 8'd100;
                else                           m[(i*R + j)*W +: W] = W'((i*11 + j*29 + 3) % D);
            end
        end
        m[(0*R + K)*W +: W]       = 8'd7;
        m[((C-1)*R + K)*W +: W]   = 8'd7;
        m[((C/2)*R + K)*W +: W]   = 8'd0;
        for (int t = 1; t < C; t++) begin
            m[((t-1)*R + K + t)*W +: W] = 8'd0;
            m[(t*R + K + t)*W +: W]     = 8'd0;
        end
        for (int j = 0; j < K; j++) rand_info[j] = {$urandom(), $urandom(), $urandom()};

        vecs[0] = '{kind: 0, bp: 4'b1111, zero_par: 1'b1, same_prev: 1'b0};
        vecs[1] = '{kind: 1, bp: 4'b1111, zero_par: 1'b0, same_prev: 1'b0};
        vecs[2] = '{kind: 2, bp: 4'b1111, zero_par: 1'b0, same_prev: 1'b0};
        vecs[3] = '{kind: 2, bp: 4'b1001, zero_par: 1'b0, same_prev: 1'b1};
        vecs[4] = '{kind: 3, bp: 4'b1011, zero_par: 1'b0, same_prev: 1'b0};

        // Reset state while rst is held
        rst = 1'b1; in_valid = 1'b0; in_data = {D{1'b0}}; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk1("rst/busy", busy, 1'b0);
        chk1("rst/last", out_last, 1'b0);
        chk1("rst/ovalid0", out_valid, 1'b0);
        chk1("rst/iready", in_ready, 1'b1);
        in_valid = 1'b1; in_data = 96'h0000_0000_0000_0000_0000_005A; #1;
        chk1("rst/ovalid1", out_valid, 1'b1);
        chk("rst/odata", out_data, 96'h0000_0000_0000_0000_0000_005A);
        in_valid = 1'b0; out_ready = 1'b0; #1;
        chk1("rst/iready0", in_ready, 1'b0);
        out_ready = 1'b1;
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < K; j++) begin
                case (vecs[v].kind)
                    0:       info[j] = {D{1'b0}};
                    1:       info[j] = (j == 0) ? 96'h1 : {D{1'b0}};
                    2:       info[j] = rand_info[j];
                    default: info[j] = {D{1'b1}};
                endcase
            end
            run(1, vecs[v].bp, 2*R);
            check_cw(0, vecs[v].bp, vecs[v].zero_par, vecs[v].same_prev, $sformatf("v%0d", v));
            @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
            chk1($sformatf("v%0d/busy_end", v), busy, 1'b0);
        end

        // Abort a codeword with reset at PAR t=5, then encode a fresh one
        for (int j = 0; j < K; j++) info[j] = {$urandom(), $urandom(), $urandom()};
        run(1, 4'b1111, K + 5);
        @(negedge clk); in_valid = 1'b0; #1;
        chk1("abort/busy_pre", busy, 1'b1);
        chk1("abort/ovalid_pre", out_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk1("abort/ovalid", out_valid, 1'b0);
        chk1("abort/busy", busy, 1'b0);
        chk1("abort/last", out_last, 1'b0);
        chk1("abort/iready", in_ready, 1'b1);
        in_valid = 1'b1; in_data = 96'hA5; #1;
        chk1("abort/ovalid1", out_valid, 1'b1);
        chk("abort/odata", out_data, 96'hA5);
        in_valid = 1'b0;
        rst = 1'b0;
        for (int j = 0; j < K; j++) info[j] = {$urandom(), $urandom(), $urandom()};
        run(1, 4'b1111, 2*R);
        check_cw(0, 4'b1111, 1'b0, 1'b0, "post_rst");

        // Two codewords back to back with in_valid held high
        for (int j = 0; j < 2*K; j++) info[j] = {$urandom(), $urandom(), $urandom()};
        run(2, 4'b1111, 2*R);
        check_cw(0, 4'b1111, 1'b0, 1'b0, "b2b0");
        check_cw(1, 4'b1111, 1'b0, 1'b0, "b2b1");
        chk("b2b/s0_cycle", D'(in_cyc[K]), D'(out_cyc[R-1] + 1));
        @(negedge clk); in_valid = 1'b0; #1;
        chk1("b2b/busy_end", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
